// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg
//   Shared constants and types for the MEM/WB pipeline register slice.
//   XLEN        : datapath width
//   REG_ADDR_W  : register address width
//   wb_sel_e    : writeback source select encodings
package mem_wb_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_RSV = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/mem_wb_stage_wb_value_mux.sv
// wb_value_mux
//   Writeback value select for the WB stage. Reserved encoding falls back
//   to the ALU result; an empty (bubble) stage drives zero so nothing stale
//   reaches the forwarding path.
//   sel_i   : registered writeback select
//   alu_i   : registered ALU result
//   rdata_i : registered load data
//   pc4_i   : registered PC+4
//   valid_i : WB stage holds a real instruction
//   value_o : register-file write data / forwarding source
module wb_value_mux
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = mem_wb_stage_pkg::XLEN
) (
  input  wb_sel_e          sel_i,
  input  logic [XLEN-1:0]  alu_i,
  input  logic [XLEN-1:0]  rdata_i,
  input  logic [XLEN-1:0]  pc4_i,
  input  logic             valid_i,
  output logic [XLEN-1:0]  value_o
);

  always_comb begin
    value_o = '0;
    if (valid_i) begin
      unique case (sel_i)
        WB_SEL_MEM: value_o = rdata_i;
        WB_SEL_PC4: value_o = pc4_i;
        default:    value_o = alu_i;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register plus writeback value select (RV32IM 5-stage).
//   Captures memory-stage results each edge; FLUSH_WB or MEM_BUSYWAIT load
//   a bubble instead. Async active-low reset.
//   Inputs : CLK, RESET, REG_WRITE_EN_MEM, WB_VALUE_SEL_MEM, MEM_READ_EN_MEM,
//            PC_4_MEM, ALU_RESULT, READ_DATA, REG_WRITE_ADDR_MEM,
//            MEM_BUSYWAIT, FLUSH_WB
//   Outputs: REG_WRITE_EN_WB, MEM_READ_EN_WB, REG_WRITE_ADDR_WB,
//            Wb_Select_Mux_Out, WB_VALID
//   Optional: MEMWB_PERF_CNT_EN adds INSTRET_CNT, LOAD_CNT, STALL_CNT.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN       = mem_wb_stage_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = mem_wb_stage_pkg::REG_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REG_WRITE_EN_MEM,
  input  logic [1:0]            WB_VALUE_SEL_MEM,
  input  logic                  MEM_READ_EN_MEM,
  input  logic [XLEN-1:0]       PC_4_MEM,
  input  logic [XLEN-1:0]       ALU_RESULT,
  input  logic [XLEN-1:0]       READ_DATA,
  input  logic [REG_ADDR_W-1:0] REG_WRITE_ADDR_MEM,
  input  logic                  MEM_BUSYWAIT,
  input  logic                  FLUSH_WB,
  output logic                  REG_WRITE_EN_WB,
  output logic                  MEM_READ_EN_WB,
  output logic [REG_ADDR_W-1:0] REG_WRITE_ADDR_WB,
  output logic [XLEN-1:0]       Wb_Select_Mux_Out,
  output logic                  WB_VALID
`ifdef MEMWB_PERF_CNT_EN
  ,
  output logic [31:0]           INSTRET_CNT,
  output logic [31:0]           LOAD_CNT,
  output logic [31:0]           STALL_CNT
`endif
);

  logic                  valid_q, valid_d;
  logic                  we_q,    we_d;
  logic                  mre_q,   mre_d;
  logic [REG_ADDR_W-1:0] addr_q,  addr_d;
  wb_sel_e               sel_q,   sel_d;
  logic [XLEN-1:0]       alu_q,   alu_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic [XLEN-1:0]       pc4_q,   pc4_d;

  logic bubble;
  assign bubble = FLUSH_WB | MEM_BUSYWAIT;

  // Control fields clear on a bubble; data fields simply hold.
  always_comb begin
    valid_d = 1'b0;
    we_d    = 1'b0;
    mre_d   = 1'b0;
    addr_d  = '0;
    sel_d   = sel_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc4_d   = pc4_q;
    if (!bubble) begin
      valid_d = 1'b1;
      we_d    = REG_WRITE_EN_MEM;
      mre_d   = MEM_READ_EN_MEM;
      addr_d  = REG_WRITE_ADDR_MEM;
      sel_d   = wb_sel_e'(WB_VALUE_SEL_MEM);
      alu_d   = ALU_RESULT;
      rdata_d = READ_DATA;
      pc4_d   = PC_4_MEM;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      mre_q   <= 1'b0;
      addr_q  <= '0;
      sel_q   <= WB_SEL_ALU;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      mre_q   <= mre_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc4_q   <= pc4_d;
    end
  end

  // x0 is never written; WB_VALID still reports the instruction.
  assign REG_WRITE_EN_WB   = we_q & (addr_q != '0);
  assign MEM_READ_EN_WB    = mre_q;
  assign REG_WRITE_ADDR_WB = addr_q;
  assign WB_VALID          = valid_q;

  wb_value_mux #(.XLEN(XLEN)) u_wb_value_mux (
    .sel_i   (sel_q),
    .alu_i   (alu_q),
    .rdata_i (rdata_q),
    .pc4_i   (pc4_q),
    .valid_i (valid_q),
    .value_o (Wb_Select_Mux_Out)
  );

`ifdef MEMWB_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] load_q,    load_d;
  logic [31:0] stall_q,   stall_d;

  always_comb begin
    instret_d = instret_q + 32'(!bubble);
    load_d    = load_q    + 32'(!bubble && MEM_READ_EN_MEM);
    stall_d   = stall_q   + 32'(MEM_BUSYWAIT && !FLUSH_WB);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      instret_q <= '0;
      load_q    <= '0;
      stall_q   <= '0;
    end else begin
      instret_q <= instret_d;
      load_q    <= load_d;
      stall_q   <= stall_d;
    end
  end

  assign INSTRET_CNT = instret_q;
  assign LOAD_CNT    = load_q;
  assign STALL_CNT   = stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage with an instruction-level reference
//   model and a negedge compare process. Honors MEMWB_PERF_CNT_EN.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REG_WRITE_EN_MEM;
  logic [1:0]  WB_VALUE_SEL_MEM;
  logic        MEM_READ_EN_MEM;
  logic [31:0] PC_4_MEM;
  logic [31:0] ALU_RESULT;
  logic [31:0] READ_DATA;
  logic [4:0]  REG_WRITE_ADDR_MEM;
  logic        MEM_BUSYWAIT;
  logic        FLUSH_WB;
  logic        REG_WRITE_EN_WB;
  logic        MEM_READ_EN_WB;
  logic [4:0]  REG_WRITE_ADDR_WB;
  logic [31:0] Wb_Select_Mux_Out;
  logic        WB_VALID;
`ifdef MEMWB_PERF_CNT_EN
  logic [31:0] INSTRET_CNT, LOAD_CNT, STALL_CNT;
`endif

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .REG_WRITE_EN_MEM   (REG_WRITE_EN_MEM),
    .WB_VALUE_SEL_MEM   (WB_VALUE_SEL_MEM),
    .MEM_READ_EN_MEM    (MEM_READ_EN_MEM),
    .PC_4_MEM           (PC_4_MEM),
    .ALU_RESULT         (ALU_RESULT),
    .READ_DATA          (READ_DATA),
    .REG_WRITE_ADDR_MEM (REG_WRITE_ADDR_MEM),
    .MEM_BUSYWAIT       (MEM_BUSYWAIT),
    .FLUSH_WB           (FLUSH_WB),
    .REG_WRITE_EN_WB    (REG_WRITE_EN_WB),
    .MEM_READ_EN_WB     (MEM_READ_EN_WB),
    .REG_WRITE_ADDR_WB  (REG_WRITE_ADDR_WB),
    .Wb_Select_Mux_Out  (Wb_Select_Mux_Out),
    .WB_VALID           (WB_VALID)
`ifdef MEMWB_PERF_CNT_EN
    ,
    .INSTRET_CNT        (INSTRET_CNT),
    .LOAD_CNT           (LOAD_CNT),
    .STALL_CNT          (STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the WB stage must present, decided per instruction.
  logic        m_valid, m_we, m_mre;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_instret, m_load, m_stall;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_valid <= 0; m_we <= 0; m_mre <= 0; m_addr <= 0; m_data <= 0;
      m_instret <= 0; m_load <= 0; m_stall <= 0;
    end else begin
      if (MEM_BUSYWAIT && !FLUSH_WB) m_stall <= m_stall + 1;
      if (FLUSH_WB || MEM_BUSYWAIT) begin
        m_valid <= 0; m_we <= 0; m_mre <= 0; m_addr <= 0; m_data <= 0;
      end else begin
        m_valid <= 1;
        m_we    <= REG_WRITE_EN_MEM && (REG_WRITE_ADDR_MEM != 0);
        m_mre   <= MEM_READ_EN_MEM;
        m_addr  <= REG_WRITE_ADDR_MEM;
        m_data  <= (WB_VALUE_SEL_MEM == 2'd1) ? READ_DATA :
                   (WB_VALUE_SEL_MEM == 2'd2) ? PC_4_MEM : ALU_RESULT;
        m_instret <= m_instret + 1;
        if (MEM_READ_EN_MEM) m_load <= m_load + 1;
      end
    end
  end

  always @(negedge CLK) begin
    check("cmp_we",    32'(REG_WRITE_EN_WB),   32'(m_we));
    check("cmp_mre",   32'(MEM_READ_EN_WB),    32'(m_mre));
    check("cmp_addr",  32'(REG_WRITE_ADDR_WB), 32'(m_addr));
    check("cmp_valid", 32'(WB_VALID),          32'(m_valid));
    check("cmp_data",  Wb_Select_Mux_Out,      m_data);
`ifdef MEMWB_PERF_CNT_EN
    check("cmp_instret", INSTRET_CNT, m_instret);
    check("cmp_load",    LOAD_CNT,    m_load);
    check("cmp_stall",   STALL_CNT,   m_stall);
`endif
  end

  task automatic drive(input logic we, input logic [1:0] sel, input logic mre,
                       input logic [4:0] addr, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] pc4,
                       input logic busy, input logic flush);
    REG_WRITE_EN_MEM = we; WB_VALUE_SEL_MEM = sel; MEM_READ_EN_MEM = mre;
    REG_WRITE_ADDR_MEM = addr; ALU_RESULT = alu; READ_DATA = rd;
    PC_4_MEM = pc4; MEM_BUSYWAIT = busy; FLUSH_WB = flush;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_wb(input string name, input logic we, input logic mre,
                          input logic [4:0] addr, input logic valid,
                          input logic [31:0] data);
    check({name, "_we"},    32'(REG_WRITE_EN_WB),   32'(we));
    check({name, "_mre"},   32'(MEM_READ_EN_WB),    32'(mre));
    check({name, "_addr"},  32'(REG_WRITE_ADDR_WB), 32'(addr));
    check({name, "_valid"}, 32'(WB_VALID),          32'(valid));
    check({name, "_data"},  Wb_Select_Mux_Out,      data);
  endtask

`ifdef MEMWB_PERF_CNT_EN
  logic [31:0] b_ins, b_ld, b_st;
`endif

  initial begin
    RESET = 1'b0;
    drive(0, 2'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    #12;
    check_wb("reset", 0, 0, 5'd0, 0, 32'h0);
    RESET = 1'b1;

    // 1: ALU writeback
    drive(1, 2'd0, 0, 5'd5, 32'h0000_1234, 32'hAAAA_0000, 32'h0000_0040, 0, 0);
    tick();
    check_wb("alu", 1, 0, 5'd5, 1, 32'h0000_1234);

    // 2: load
    drive(1, 2'd1, 1, 5'd7, 32'h0000_2000, 32'hFFFF_FF80, 32'h0000_0044, 0, 0);
    tick();
    check_wb("load", 1, 1, 5'd7, 1, 32'hFFFF_FF80);

    // 3: PC+4 and reserved encoding
    drive(1, 2'd2, 0, 5'd1, 32'h0000_0777, 32'h1111_1111, 32'h0000_0104, 0, 0);
    tick();
    check_wb("jal", 1, 0, 5'd1, 1, 32'h0000_0104);
    drive(1, 2'd3, 0, 5'd2, 32'h0000_0888, 32'h1111_1111, 32'h0000_0108, 0, 0);
    tick();
    check_wb("rsv", 1, 0, 5'd2, 1, 32'h0000_0888);

    // 4: three busywait edges then release, load to x9
`ifdef MEMWB_PERF_CNT_EN
    b_ins = INSTRET_CNT; b_ld = LOAD_CNT; b_st = STALL_CNT;
`endif
    drive(1, 2'd1, 1, 5'd9, 32'h0000_3000, 32'h0000_00AB, 32'h0000_010C, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_wb("stall", 0, 0, 5'd0, 0, 32'h0);
    end
    MEM_BUSYWAIT = 1'b0;
    tick();
    check_wb("unstall", 1, 1, 5'd9, 1, 32'h0000_00AB);
`ifdef MEMWB_PERF_CNT_EN
    check("stall_delta",   STALL_CNT - b_st,    32'd3);
    check("instret_delta", INSTRET_CNT - b_ins, 32'd1);
    check("load_delta",    LOAD_CNT - b_ld,     32'd1);
`endif
    MEM_BUSYWAIT = 1'b1;
    tick();
    check_wb("no_dup", 0, 0, 5'd0, 0, 32'h0);

    // 5: write to x0
    drive(1, 2'd0, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0);
    tick();
    check_wb("x0", 0, 0, 5'd0, 1, 32'hDEAD_BEEF);

    // 6: flush alone, flush with busywait
    drive(1, 2'd0, 1, 5'd4, 32'h0000_0044, 32'h0, 32'h0, 0, 1);
    tick();
    check_wb("flush", 0, 0, 5'd0, 0, 32'h0);
    drive(1, 2'd0, 0, 5'd6, 32'h0000_0066, 32'h0, 32'h0, 1, 1);
    tick();
    check_wb("flush_busy", 0, 0, 5'd0, 0, 32'h0);

    // 6b: async reset while a valid instruction sits in WB and a stall is pending
    drive(1, 2'd0, 0, 5'd3, 32'h0000_0055, 32'h0, 32'h0, 0, 0);
    tick();
    check_wb("pre_rst", 1, 0, 5'd3, 1, 32'h0000_0055);
    MEM_BUSYWAIT = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    check_wb("async_rst", 0, 0, 5'd0, 0, 32'h0);
`ifdef MEMWB_PERF_CNT_EN
    check("rst_instret", INSTRET_CNT, 32'd0);
`endif
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    tick();
    check_wb("post_rst_stall", 0, 0, 5'd0, 0, 32'h0);
    MEM_BUSYWAIT = 1'b0;
    tick();
    check_wb("post_rst_cap", 1, 0, 5'd3, 1, 32'h0000_0055);
`ifdef MEMWB_PERF_CNT_EN
    check("post_rst_stall_cnt", STALL_CNT,   32'd1);
    check("post_rst_instret",   INSTRET_CNT, 32'd1);
`endif

    drive(0, 2'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    tick();
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback value select for the RV32IM 5-stage pipeline. Sits directly downstream of the memory stage.
- Captures memory-stage results each cycle and inserts a bubble while data memory is busy.
- Drives the register-file write port, Wb_Select_Mux_Out and the WB-side signals used by memory-stage store-data forwarding.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- REG_WRITE_EN_MEM  in  1  register write enable from the memory stage.
- WB_VALUE_SEL_MEM  in  2  writeback source select.
- MEM_READ_EN_MEM  in  1  instruction is a load.
- PC_4_MEM  in  XLEN  PC+4 of the memory-stage instruction.
- ALU_RESULT  in  XLEN  ALU result or effective address.
- READ_DATA  in  XLEN  load data from the cache controller, already extended.
- REG_WRITE_ADDR_MEM  in  REG_ADDR_W  destination register.
- MEM_BUSYWAIT  in  1  data memory not finished this cycle.
- FLUSH_WB  in  1  synchronous kill of the instruction entering WB.
- REG_WRITE_EN_WB  out  1  register-file write enable.
- MEM_READ_EN_WB  out  1  WB instruction is a load; feeds store-data forwarding.
- REG_WRITE_ADDR_WB  out  REG_ADDR_W  register-file write address.
- Wb_Select_Mux_Out  out  XLEN  register-file write data; also the forwarding source.
- WB_VALID  out  1  a real (non-bubble) instruction occupies WB.

Behaviour:
- Reset (RESET=0, asynchronous):
  - All pipeline registers clear to 0.
  - Outputs: REG_WRITE_EN_WB=0, MEM_READ_EN_WB=0, REG_WRITE_ADDR_WB=0, WB_VALID=0, Wb_Select_Mux_Out=0.
  - Deassertion takes effect at the next rising CLK edge.
- Latency: one cycle. Inputs sampled at edge N appear on the WB outputs after edge N.
- Load rule, evaluated each rising edge in priority order:
  1. FLUSH_WB=1 -> bubble.
  2. MEM_BUSYWAIT=1 -> bubble.
  3. Otherwise capture all MEM-side inputs and set WB_VALID=1.
- Bubble definition:
  - WB_VALID=0, REG_WRITE_EN_WB=0, MEM_READ_EN_WB=0, REG_WRITE_ADDR_WB=0.
  - Data registers hold their previous value; they are don't-care.
- Rationale for bubbling on busywait: upstream stages freeze, so the instruction already in WB retires exactly once and the stalled memory instruction enters WB only once.
- Writeback mux, combinational from registered fields:
  - 00 -> ALU result.
  - 01 -> read data.
  - 10 -> PC+4.
  - 11 -> ALU result (reserved encoding).
- x0 guard:
  - REG_WRITE_EN_WB is forced to 0 when REG_WRITE_ADDR_WB=0, even if the captured enable was 1.
  - WB_VALID is unaffected by the x0 guard.
- A bubble forces Wb_Select_Mux_Out to 0, so no stale data leaks through the forwarding path.
- Simultaneous FLUSH_WB and MEM_BUSYWAIT: bubble (same result either way).
- Reset asserted mid-stall: state clears immediately; after release the first edge with MEM_BUSYWAIT=0 captures normally.
- Back-to-back busywait cycles: continuous bubbles, no duplicate retirement.

Optional Feature:
- Macro: MEMWB_PERF_CNT_EN.
- When defined, three 32-bit counters are added, each reset to 0 and wrapping modulo 2^32:
  - INSTRET_CNT: increments on every edge that captures a valid instruction.
  - LOAD_CNT: increments when that captured instruction has MEM_READ_EN_MEM=1.
  - STALL_CNT: increments on every edge with MEM_BUSYWAIT=1 and FLUSH_WB=0.
- Counters are exposed as extra output ports of the same names.
- When not defined, the counters and their ports do not exist, and the behaviour above is unchanged.

Decomposition:
- Shared package: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10, XLEN, REG_ADDR_W.
- Sub-module: wb_value_mux (4:1 select implementing the encodings and the bubble-zero rule).

Test Plan:
1. Reset release, idle inputs -> all outputs 0, WB_VALID=0; after one clean edge with REG_WRITE_EN_MEM=1, addr=5, sel=00, ALU_RESULT=0x0000_1234 -> REG_WRITE_EN_WB=1, REG_WRITE_ADDR_WB=5, Wb_Select_Mux_Out=0x0000_1234.
2. Load: sel=01, READ_DATA=0xFFFF_FF80, MEM_READ_EN_MEM=1, addr=7 -> next cycle Wb_Select_Mux_Out=0xFFFF_FF80, MEM_READ_EN_WB=1.
3. JAL-type: sel=10, PC_4_MEM=0x0000_0104, addr=1 -> Wb_Select_Mux_Out=0x0000_0104; with sel=11 -> ALU_RESULT value.
4. MEM_BUSYWAIT high for 3 cycles then low, inputs fixed (load to x9) -> 3 bubble cycles with REG_WRITE_EN_WB=0, then exactly one cycle with addr 9; with MEMWB_PERF_CNT_EN: STALL_CNT=3, INSTRET_CNT=1, LOAD_CNT=1.
5. Write to x0 (addr=0, enable=1, ALU_RESULT=0xDEAD_BEEF) -> REG_WRITE_EN_WB=0, WB_VALID=1.
6. FLUSH_WB=1 together with MEM_BUSYWAIT=1 -> bubble. RESET driven low mid-stall with asynchronous timing -> outputs 0 before the next edge.
